// File: rtl/dcache_wt_dm.sv
// dcache_wt_dm: direct-mapped, write-through, no-write-allocate data cache.
//
// Sits between the core data port and main memory. A core request is
// captured whenever stall is low and looked up in the following cycle.
// Load hits return data in the lookup cycle. Load misses refill one
// 16-byte line over the memory channel. Every store is written through
// to memory, and stores that hit also update the cached line.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   dcache_addr/re/we/din  core request (captured while stall == 0)
//   dcache_dout         load word for the previous cycle's request
//   stall               freezes the core pipeline (combinational)
//   mem_req_*           single-beat 128-bit valid/ready request channel
//   mem_resp_valid/data valid-only refill response channel
//
// Optional feature: define DCACHE_STATS_EN to add the stat_hits and
// stat_misses load lookup counters.
module dcache_wt_dm #(
    parameter int unsigned NUM_LINES = 64,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   dcache_addr,
    input  logic                dcache_re,
    input  logic [3:0]          dcache_we,
    input  logic [31:0]         dcache_din,
    output logic [31:0]         dcache_dout,
    output logic                stall,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [ADDR_W-5:0]   mem_req_addr,
    output logic [127:0]        mem_req_data,
    output logic [15:0]         mem_req_mask,
    input  logic                mem_resp_valid,
    input  logic [127:0]        mem_resp_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_REFILL_DONE,
        S_WRITE_REQ
    } state_t;

    state_t state_q, state_d;

    // Captured core request; byte offset bits are never needed
    logic                req_q;
    logic [ADDR_W-1:2]   addr_q;
    logic [3:0]          we_q;
    logic [31:0]         din_q;
    logic [31:0]         dout_q;
    logic                unused_addr_lsb;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [127:0]         data_mem [NUM_LINES];

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [1:0]          wsel;
    logic [127:0]        line_rd;
    logic [31:0]         line_word;
    logic [15:0]         wr_mask;
    logic [127:0]        wr_data;
    logic [127:0]        merged_line;
    logic                hit;
    logic                is_store;

    logic                refill;
    logic                store_upd;
    logic                dout_upd;
    logic                hit_ev;
    logic                miss_ev;

    assign unused_addr_lsb = ^dcache_addr[1:0];

    // Address decode of the captured request
    assign idx       = addr_q[IDX_W+3:4];
    assign tag       = addr_q[ADDR_W-1:IDX_W+4];
    assign wsel      = addr_q[3:2];
    assign line_rd   = data_mem[idx];
    assign line_word = line_rd[{wsel, 5'd0} +: 32];
    assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
    assign is_store  = |we_q;

    // Store payload: word replicated in all lanes, mask selects the lane
    assign wr_data = {4{din_q}};
    assign wr_mask = 16'(we_q) << {wsel, 2'b00};

    assign mem_req_addr = addr_q[ADDR_W-1:4];
    assign mem_req_data = wr_data;
    assign mem_req_mask = wr_mask;

    // Byte merge of a store hit into the cached line
    always_comb begin
        merged_line = line_rd;
        for (int b = 0; b < 16; b++) begin
            if (wr_mask[b]) begin
                merged_line[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    // Request capture; held while the pipeline is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            we_q   <= '0;
            din_q  <= '0;
        end else if (!stall) begin
            req_q  <= dcache_re | (|dcache_we);
            addr_q <= dcache_addr[ADDR_W-1:2];
            we_q   <= dcache_we;
            din_q  <= dcache_din;
        end
    end

    // FSM state and load-data hold registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dout_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (dout_upd) begin
                dout_q <= dcache_dout;
            end
            if (refill) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (refill) begin
            data_mem[idx] <= mem_resp_data;
            tag_mem[idx]  <= tag;
        end else if (store_upd) begin
            data_mem[idx] <= merged_line;
        end
    end

    // Next state, stall and memory request generation
    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        dcache_dout   = dout_q;
        refill        = 1'b0;
        store_upd     = 1'b0;
        dout_upd      = 1'b0;
        hit_ev        = 1'b0;
        miss_ev       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_q) begin
                    if (is_store) begin
                        mem_req_valid = 1'b1;
                        mem_req_rw    = 1'b1;
                        stall         = ~mem_req_ready;
                        if (mem_req_ready) begin
                            store_upd = hit;
                        end else begin
                            state_d = S_WRITE_REQ;
                        end
                    end else if (hit) begin
                        dcache_dout = line_word;
                        dout_upd    = 1'b1;
                        hit_ev      = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        miss_ev = 1'b1;
                        state_d = S_MISS_REQ;
                    end
                end
            end
            S_MISS_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = S_MISS_WAIT;
                end
            end
            S_MISS_WAIT: begin
                stall = 1'b1;
                if (mem_resp_valid) begin
                    refill  = 1'b1;
                    state_d = S_REFILL_DONE;
                end
            end
            S_REFILL_DONE: begin
                dcache_dout = line_word;
                dout_upd    = 1'b1;
                state_d     = S_IDLE;
            end
            S_WRITE_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                stall         = ~mem_req_ready;
                if (mem_req_ready) begin
                    store_upd = hit;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    // Load lookup counters, one event per request at lookup time
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (hit_ev) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (miss_ev) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`else
    logic unused_stat_ev;
    assign unused_stat_ev = hit_ev ^ miss_ev;
`endif

endmodule

// File: tb/tb_dcache_wt_dm.sv
// Directed testbench for dcache_wt_dm (default build, 64 lines, 32-bit address).
module tb_dcache_wt_dm;

    logic         clk;
    logic         reset;
    logic [31:0]  dcache_addr;
    logic         dcache_re;
    logic [3:0]   dcache_we;
    logic [31:0]  dcache_din;
    logic [31:0]  dcache_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic [15:0]  mem_req_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    int total = 0;
    int bad   = 0;

    // Memory model state
    logic         mute_resp  = 1'b0;
    logic         stray_pulse = 1'b0;
    int           rd_count   = 0;
    int           wr_count   = 0;
    logic [27:0]  last_rd_addr = '0;
    logic [27:0]  last_wr_addr = '0;
    logic [127:0] last_wr_data = '0;
    logic [15:0]  last_wr_mask = '0;

    dcache_wt_dm dut (
        .clk            (clk),
        .reset          (reset),
        .dcache_addr    (dcache_addr),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_din     (dcache_din),
        .dcache_dout    (dcache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line contents held by main memory
    function automatic logic [127:0] line_of(input logic [27:0] la);
        logic [31:0] base;
        if (la == 28'h10) begin
            return {32'h0000_DDDD, 32'h0000_CCCC, 32'h0000_BBBB, 32'h0000_AAAA};
        end
        base = 32'hA000_0000 | {la, 4'h0};
        return {base | 32'd3, base | 32'd2, base | 32'd1, base};
    endfunction

    // Memory: accepts requests, answers reads one cycle after acceptance
    always @(posedge clk) begin
        mem_resp_valid <= 1'b0;
        if (stray_pulse) begin
            mem_resp_valid <= 1'b1;
            mem_resp_data  <= {4{32'h5555_5555}};
        end
        if (mem_req_valid && mem_req_ready) begin
            if (mem_req_rw) begin
                wr_count     <= wr_count + 1;
                last_wr_addr <= mem_req_addr;
                last_wr_data <= mem_req_data;
                last_wr_mask <= mem_req_mask;
            end else begin
                rd_count     <= rd_count + 1;
                last_rd_addr <= mem_req_addr;
                if (!mute_resp) begin
                    mem_resp_valid <= 1'b1;
                    mem_resp_data  <= line_of(mem_req_addr);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        dcache_re   = 1'b0;
        dcache_we   = 4'h0;
        dcache_addr = 32'hDEAD_BEE0;
        dcache_din  = 32'hFFFF_FFFF;
    endtask

    // Issue one request at posedge+1; return stalled cycles and completion dout
    task automatic do_req(input logic [31:0] a, input logic re, input logic [3:0] we,
                          input logic [31:0] d, output int n, output logic [31:0] dout_o);
        dcache_addr = a;
        dcache_re   = re;
        dcache_we   = we;
        dcache_din  = d;
        @(posedge clk); #1;
        idle_inputs();
        n = 0;
        @(negedge clk);
        while (stall && n < 40) begin
            n++;
            @(negedge clk);
        end
        dout_o = dcache_dout;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rd0;
        int wr0;
        logic [31:0] d;
        logic [127:0] wd;
        int stall_cnt;
        int field_err;

        reset         = 1'b0;
        mem_req_ready = 1'b1;
        idle_inputs();

        // Reset state
        #12;
        chk("rst_stall", 128'(stall), 128'(0));
        chk("rst_valid", 128'(mem_req_valid), 128'(0));
        chk("rst_dout", 128'(dcache_dout), 128'(0));
        @(posedge clk); #1;
        reset = 1'b1;

        // Cold load miss then hit in the same line
        do_req(32'h100, 1'b1, 4'h0, 32'h0, n, d);
        chk("miss_stall_cycles", 128'(n), 128'(3));
        chk("miss_dout", 128'(d), 128'h0000_AAAA);
        chk("miss_rd_count", 128'(rd_count), 128'(1));
        chk("miss_rd_addr", 128'(last_rd_addr), 128'h10);
        do_req(32'h104, 1'b1, 4'h0, 32'h0, n, d);
        chk("hit_stall", 128'(n), 128'(0));
        chk("hit_dout", 128'(d), 128'h0000_BBBB);
        chk("hit_no_refill", 128'(rd_count), 128'(1));

        // Word store hit, then load it back
        do_req(32'h108, 1'b0, 4'hF, 32'h1234_5678, n, d);
        wd = last_wr_data;
        chk("st_stall", 128'(n), 128'(0));
        chk("st_wr_count", 128'(wr_count), 128'(1));
        chk("st_mask", 128'(last_wr_mask), 128'h0F00);
        chk("st_data_w2", 128'(wd[95:64]), 128'h1234_5678);
        chk("st_addr", 128'(last_wr_addr), 128'h10);
        do_req(32'h108, 1'b1, 4'h0, 32'h0, n, d);
        chk("st_hit_stall", 128'(n), 128'(0));
        chk("st_hit_dout", 128'(d), 128'h1234_5678);

        // Byte store miss: written through, no allocation
        rd0 = rd_count;
        do_req(32'h2002, 1'b0, 4'b0100, 32'h00AB_0000, n, d);
        wd = last_wr_data;
        chk("stm_stall", 128'(n), 128'(0));
        chk("stm_mask", 128'(last_wr_mask), 128'h0004);
        chk("stm_data_w0", 128'(wd[31:0]), 128'h00AB_0000);
        chk("stm_addr", 128'(last_wr_addr), 128'h200);
        chk("stm_no_refill", 128'(rd_count), 128'(rd0));
        do_req(32'h2000, 1'b1, 4'h0, 32'h0, n, d);
        chk("stm_load_miss", 128'(n), 128'(3));
        chk("stm_load_dout", 128'(d), 128'hA000_2000);
        chk("stm_load_rd", 128'(rd_count), 128'(rd0 + 1));

        // Aliasing addresses evict each other
        rd0 = rd_count;
        do_req(32'h500, 1'b1, 4'h0, 32'h0, n, d);
        chk("alias1_miss", 128'(n), 128'(3));
        chk("alias1_dout", 128'(d), 128'hA000_0500);
        do_req(32'h100, 1'b1, 4'h0, 32'h0, n, d);
        chk("alias2_miss", 128'(n), 128'(3));
        chk("alias2_dout", 128'(d), 128'h0000_AAAA);
        do_req(32'h500, 1'b1, 4'h0, 32'h0, n, d);
        chk("alias3_miss", 128'(n), 128'(3));
        do_req(32'h100, 1'b1, 4'h0, 32'h0, n, d);
        chk("alias4_miss", 128'(n), 128'(3));
        chk("alias_rd_count", 128'(rd_count), 128'(rd0 + 4));
        chk("alias_rd_addr", 128'(last_rd_addr), 128'h10);

        // Store held off by mem_req_ready for 5 cycles
        rd0 = rd_count;
        wr0 = wr_count;
        mem_req_ready = 1'b0;
        dcache_addr = 32'h10C;
        dcache_re   = 1'b0;
        dcache_we   = 4'hF;
        dcache_din  = 32'hCAFE_F00D;
        @(posedge clk); #1;
        dcache_addr = 32'h3000;
        dcache_re   = 1'b1;
        dcache_we   = 4'h0;
        dcache_din  = 32'h0;
        stall_cnt = 0;
        field_err = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (!(mem_req_valid === 1'b1 && mem_req_rw === 1'b1 &&
                  mem_req_addr === 28'h10 && mem_req_mask === 16'hF000 &&
                  mem_req_data === {4{32'hCAFE_F00D}})) field_err++;
            @(posedge clk); #1;
        end
        idle_inputs();
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("hold_stall_cycles", 128'(stall_cnt), 128'(5));
        chk("hold_fields_stable", 128'(field_err), 128'(0));
        chk("hold_release_stall", 128'(stall), 128'(0));
        chk("hold_release_valid", 128'(mem_req_valid), 128'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_wr_count", 128'(wr_count), 128'(wr0 + 1));
        chk("hold_no_capture", 128'(rd_count), 128'(rd0));
        do_req(32'h10C, 1'b1, 4'h0, 32'h0, n, d);
        chk("hold_hit_stall", 128'(n), 128'(0));
        chk("hold_hit_dout", 128'(d), 128'hCAFE_F00D);

        // Reset in MISS_WAIT abandons the refill
        mute_resp   = 1'b1;
        dcache_addr = 32'h500;
        dcache_re   = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("mw_lookup_stall", 128'(stall), 128'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("mw_req_valid", 128'(mem_req_valid), 128'(1));
        chk("mw_req_rw", 128'(mem_req_rw), 128'(0));
        chk("mw_req_addr", 128'(mem_req_addr), 128'h50);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mw_wait_stall", 128'(stall), 128'(1));
        chk("mw_wait_valid", 128'(mem_req_valid), 128'(0));
        reset = 1'b0;
        #1;
        chk("mw_rst_stall", 128'(stall), 128'(0));
        chk("mw_rst_valid", 128'(mem_req_valid), 128'(0));
        chk("mw_rst_dout", 128'(dcache_dout), 128'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset       = 1'b1;
        mute_resp   = 1'b0;
        stray_pulse = 1'b1;
        @(posedge clk); #1;
        stray_pulse = 1'b0;
        @(negedge clk);
        chk("stray_stall", 128'(stall), 128'(0));
        chk("stray_valid", 128'(mem_req_valid), 128'(0));
        @(posedge clk); #1;
        rd0 = rd_count;
        do_req(32'h100, 1'b1, 4'h0, 32'h0, n, d);
        chk("post_rst_miss", 128'(n), 128'(3));
        chk("post_rst_dout", 128'(d), 128'h0000_AAAA);
        chk("post_rst_rd", 128'(rd_count), 128'(rd0 + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_wt_dm.md
Name: dcache_wt_dm

Overview:
- Direct-mapped, write-through, no-write-allocate data cache sitting directly downstream of the 3-stage RISC-V core's data port.
- Consumes the core's dcache_addr/dcache_din/dcache_we/dcache_re and returns dcache_dout one cycle later.
- Produces the core's stall input.
- Refills and write-throughs go to main memory over a single-beat 128-bit valid/ready request channel and a valid-only response channel.

Parameters:
- NUM_LINES, 64, number of 16-byte lines; power of two, >= 2; IDX_W = log2(NUM_LINES).
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- dcache_addr  in  ADDR_W  byte address from core stage 2.
- dcache_re  in  1  read request.
- dcache_we  in  4  byte write enables; nonzero = store.
- dcache_din  in  32  store data, already lane-aligned.
- dcache_dout  out  32  aligned load word for the previous cycle's request.
- stall  out  1  freezes the core pipeline.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_rw  out  1  1 = write, 0 = line read.
- mem_req_addr  out  ADDR_W-4  line address (byte addr[ADDR_W-1:4]).
- mem_req_data  out  128  write data; word w in bits [32w+31:32w].
- mem_req_mask  out  16  byte enables for writes.
- mem_resp_valid  in  1  refill line valid.
- mem_resp_data  in  128  refill line.

Behaviour:
- Address split: offset [3:0], word select [3:2], index [IDX_W+3:4], tag [ADDR_W-1:IDX_W+4].
- Request capture: a request exists when dcache_re or |dcache_we. Address, we, din and the request flag are registered when stall==0. While stall==1 the registered request is held and core inputs are ignored.
- Lookup (state IDLE, cycle after capture):
  - Tag and valid bit are read from arrays indexed by the registered address.
  - hit = valid[idx] && tag match.
- Load hit: dcache_dout = the selected word of the line, combinational in that cycle; stall = 0.
- Load miss:
  - stall = 1 combinationally in the lookup cycle; enter MISS_REQ.
  - MISS_REQ: mem_req_valid=1, rw=0, addr = line address; on mem_req_ready go to MISS_WAIT.
  - MISS_WAIT: on mem_resp_valid, write the line, tag and valid[idx]=1, then go to REFILL_DONE.
  - REFILL_DONE: dcache_dout = requested word from the installed line; stall = 0; return to IDLE.
  - Miss latency with immediate ready and response = 3 stalled cycles.
- Store (hit or miss):
  - Lookup cycle presents mem_req_valid=1, rw=1, data = din replicated into word lane [3:2], mask = we shifted to byte 4*word.
  - stall = ~mem_req_ready. If not accepted, go to WRITE_REQ and hold the request until ready, then IDLE.
  - Hit: the cached line bytes are updated per we in the accepting cycle.
  - Miss: cache state is unchanged (no allocate).
- Simultaneous re and we: treated as a store; dout undefined.
- No request in lookup cycle: stall = 0; dcache_dout holds its last value.
- mem_req_* fields stable while mem_req_valid && !mem_req_ready; mem_req_valid never drops before acceptance.
- mem_resp_valid outside MISS_WAIT is ignored.
- Reset (async, any state):
  - All valid bits cleared, FSM to IDLE, registered request flag cleared.
  - stall = 0, mem_req_valid = 0, dcache_dout = 0.
  - Tag/data arrays are not reset.
  - An outstanding memory transaction is abandoned; a later response is ignored.
- Address wrap: index uses only [IDX_W+3:4]; addresses differing only in tag alias to the same line and evict each other.

Optional Feature:
- DCACHE_STATS_EN. With the macro defined, adds outputs stat_hits[31:0] and stat_misses[31:0].
  - Each counts load lookups (hit / miss) once per request, not per stalled cycle.
  - Both wrap at 2^32 and are cleared by reset.
- Without it, neither port nor counter exists.

Test Plan:
- Reset, then load 0x100 with memory line 0x10 = {0xDDDD,0xCCCC,0xBBBB,0xAAAA} -> stall high 3 cycles, mem_req_addr=0x10 rw=0, then dout=0xAAAA; reload 0x104 -> dout=0xBBBB, no stall.
- Store word 0x12345678 to 0x108 (we=4'hF) after line 0x10 cached, mem_req_ready=1 -> mem_req_mask=16'h0F00, data[95:64]=0x12345678, stall=0; load 0x108 -> hit, dout=0x12345678.
- Store byte we=4'b0100 din=0x00AB0000 to miss address 0x2002 -> memory write mask=16'h0004, no refill issued; load 0x2000 -> miss.
- Load 0x100 then 0x100+16*NUM_LINES (alias) then 0x100 -> miss, miss, miss; three refill reads.
- Store with mem_req_ready low for 5 cycles -> stall high exactly 5 cycles, request fields constant, core inputs changed during stall are not captured.
- Assert reset during MISS_WAIT, deassert, drive stray mem_resp_valid -> ignored; load 0x100 -> misses (valid bits cleared), stall=0 and mem_req_valid=0 during reset.
